// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// flag bit positions and the iteration-counter width.
package div_restoring_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_DEF_WIDTH = 16;
  localparam int DIV_CNT_W     = $clog2(DIV_DEF_WIDTH + 1);

  localparam int FLAG_W   = 2;
  localparam int FLAG_OVF = 0;
  localparam int FLAG_DBZ = 1;

  // Counter must hold the value DATA_WIDTH itself, hence the +1.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_restoring_step #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  in_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] trial_s;
  logic [DATA_WIDTH:0] divisor_ext_s;

  assign trial_s       = {rem_in[DATA_WIDTH-1:0], in_bit};
  assign divisor_ext_s = {1'b0, divisor};

  // Trial subtraction with restore on underflow.
  always_comb begin
    rem_out = trial_s;
    q_bit   = 1'b0;
    if (trial_s >= divisor_ext_s) begin
      rem_out = trial_s - divisor_ext_s;
      q_bit   = 1'b1;
    end else begin
      rem_out = trial_s;
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready handshakes on both sides.
module div_restoring_seq
  import div_restoring_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(DATA_WIDTH);

  div_state_e       state_q, state_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s;
  logic [W:0]       rem_step_s;
  logic             q_bit_s;
  logic [W-1:0]     quo_step_s;

  div_restoring_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .rem_in (rem_q),
    .in_bit (quo_q[W-1]),
    .divisor(divisor_q),
    .rem_out(rem_step_s),
    .q_bit  (q_bit_s)
  );

  assign accept_s   = in_valid & in_ready_q;
  assign quo_step_s = {quo_q[W-2:0], q_bit_s};

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          in_ready_d = 1'b0;
          if (divisor == {W{1'b0}}) begin
            state_d           = ST_DONE;
            out_valid_d       = 1'b1;
            quotient_d        = {W{1'b1}};
            remainder_d       = dividend[W-1:0];
            flags_d           = {FLAG_W{1'b0}};
            flags_d[FLAG_DBZ] = 1'b1;
          end else if (dividend[2*W-1:W] >= divisor) begin
            // Quotient would need more than W bits.
            state_d           = ST_DONE;
            out_valid_d       = 1'b1;
            quotient_d        = {W{1'b1}};
            remainder_d       = {W{1'b0}};
            flags_d           = {FLAG_W{1'b0}};
            flags_d[FLAG_OVF] = 1'b1;
          end else begin
            state_d   = ST_CALC;
            rem_d     = {1'b0, dividend[2*W-1:W]};
            quo_d     = dividend[W-1:0];
            divisor_d = divisor;
            cnt_d     = CNT_W'(W);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          quotient_d  = quo_step_s;
          remainder_d = rem_step_s[W-1:0];
          flags_d     = {FLAG_W{1'b0}};
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= {(W+1){1'b0}};
      quo_q       <= {W{1'b0}};
      divisor_q   <= {W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {W{1'b0}};
      remainder_q <= {W{1'b0}};
      flags_q     <= {FLAG_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = flags_q[FLAG_DBZ];
  assign overflow    = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq (DATA_WIDTH=16) with a
// reference-model scoreboard.
module tb_div_restoring_seq;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
    logic           ovf;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_restoring_seq #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit division plus the flag rules.
  function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    longint unsigned a, b;
    e.dd = dd;
    e.dv = dv;
    a = 64'(dd);
    b = 64'(dv);
    if (dv == 16'd0) begin
      e.q = 16'hFFFF; e.r = dd[W-1:0]; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else if ((a / b) > 64'h0000_0000_0000_FFFF) begin
      e.q = 16'hFFFF; e.r = 16'h0000; e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = 16'(a / b); e.r = 16'(a % b); e.dbz = 1'b0; e.ovf = 1'b0; e.lat = W + 1;
    end
    return e;
  endfunction

  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    int guard;
    bit ok;
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    guard    = 0;
    ok       = 1'b0;
    while (!ok && guard < 200) begin
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got %0b, required 1 within 200 cycles", in_ready);
    end
    sb.push_back(model(dd, dv));
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   lat;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid got %b, required 1", name, out_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue size got 0, required >0", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (quotient !== e.q) begin
      errors++;
      $display("FAIL %s_quotient: %h/%h got %h, required %h", name, e.dd, e.dv, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++;
      $display("FAIL %s_remainder: %h/%h got %h, required %h", name, e.dd, e.dv, remainder, e.r);
    end
    checks++;
    if ({div_by_zero, overflow} !== {e.dbz, e.ovf}) begin
      errors++;
      $display("FAIL %s_flags: got dbz=%b ovf=%b, required dbz=%b ovf=%b",
               name, div_by_zero, overflow, e.dbz, e.ovf);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, e.lat);
    end
    if (!e.dbz && !e.ovf) begin
      checks++;
      if ((64'(quotient) * 64'(e.dv) + 64'(remainder) != 64'(e.dd)) || (remainder >= e.dv)) begin
        errors++;
        $display("FAIL %s_invariant: %h/%h got q=%h r=%h", name, e.dd, e.dv, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_consume: got out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h dbz=%b ovf=%b, required all 0",
               quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    issue(32'd100, 16'd7);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    collect("basic");
  endtask

  task automatic test_max_quotient();
    issue(32'hFFFE_0001, 16'hFFFF);
    collect("maxq_ffff");
    issue(32'h0000_FFFF, 16'd1);
    collect("maxq_div1");
    issue(32'h0006_FFFF, 16'd7);
    collect("ovf_boundary");
  endtask

  task automatic test_div_by_zero();
    issue(32'h1234_5678, 16'd0);
    collect("div_zero");
  endtask

  task automatic test_overflow();
    issue(32'h0007_0000, 16'd7);
    collect("overflow");
  endtask

  task automatic test_backpressure();
    exp_t a;
    int   guard;
    out_ready = 1'b0;
    issue(32'd100000, 16'd300);
    guard = 0;
    while (!out_valid && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    a = sb.pop_front();
    in_valid = 1'b1;
    dividend = 32'h0005_1234;
    divisor  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== a.q || remainder !== a.r) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b q=%h r=%h, required 1 0 %h %h",
                 i, out_valid, in_ready, quotient, remainder, a.q, a.r);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_consume: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    sb.push_back(model(32'h0005_1234, 16'h1234));
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: in_ready got %b, required 0", in_ready);
    end
    in_valid = 1'b0;
    collect("bp_second");
  endtask

  task automatic test_reset_mid_calc();
    out_ready = 1'b1;
    issue(32'h1234_5678, 16'h9ABC);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {quotient, remainder, div_by_zero, overflow} !== 34'd0) begin
      errors++;
      $display("FAIL midcalc_reset: got v=%b rdy=%b q=%h r=%h dbz=%b ovf=%b, required 0 1 0 0 0 0",
               out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
    end
    sb.delete();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_discard: out_valid got %b, required 0", out_valid);
    end
    issue(32'd1000, 16'd10);
    collect("after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0]   dv;
    logic [2*W-1:0] dd;
    int             mode;
    for (int n = 0; n < 2000; n++) begin
      mode = $urandom_range(0, 15);
      dv   = (mode == 0) ? 16'd0 : 16'($urandom);
      if (mode == 1) dv = 16'd1;
      dd   = $urandom;
      if (mode > 4 && dv != 16'd0) dd[2*W-1:W] = 16'($urandom % 32'(dv));
      issue(dd, dv);
      collect("random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 32'd0;
    divisor   = 16'd0;
    test_reset();
    test_basic();
    test_max_quotient();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
